instr_encoder_loader: RTL and testbench

// - Program loader and encoder: accepts symbolic instructions (kind + register fields + immediate) over a

---
 rtl/instr_encoder_loader_pkg.sv | 44 ++++
 rtl/instr_encoder_loader_word_encoder.sv | 31 +++
 rtl/instr_encoder_loader.sv | 121 ++++++++++++
 tb/tb_instr_encoder_loader.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_encoder_loader_pkg.sv
// Shared encodings for the program loader: instruction kinds, MIPS Op/Funct fields
// (the same constants the control unit decodes) and loader FSM states.
package instr_encoder_loader_pkg;

  typedef enum logic [3:0] {
    KindAdd = 4'd0,
    KindSub = 4'd1,
    KindAnd = 4'd2,
    KindOr  = 4'd3,
    KindSlt = 4'd4,
    KindLw  = 4'd5,
    KindSw  = 4'd6,
    KindBeq = 4'd7
  } kind_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StLoad  = 2'd1,
    StDone  = 2'd2,
    StError = 2'd3
  } state_e;

  function automatic logic [31:0] enc_r(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                                        logic [5:0] funct);
    return {OP_RTYPE, rs, rt, rd, 5'b00000, funct};
  endfunction

  function automatic logic [31:0] enc_i(logic [5:0] op, logic [4:0] rs, logic [4:0] rt,
                                        logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

endpackage

// File: rtl/instr_encoder_loader_word_encoder.sv
// Combinational encoder: symbolic instruction kind plus register/immediate fields to a
// 32-bit MIPS word; flags kinds outside the supported set as illegal.
module instr_word_encoder
  import instr_encoder_loader_pkg::*;
(
  input  logic [3:0]  kind_i,
  input  logic [4:0]  rs_i,
  input  logic [4:0]  rt_i,
  input  logic [4:0]  rd_i,
  input  logic [15:0] imm_i,
  output logic [31:0] word_o,
  output logic        illegal_o
);

  always_comb begin
    word_o    = '0;
    illegal_o = 1'b0;
    case (kind_i)
      KindAdd: word_o = enc_r(rs_i, rt_i, rd_i, FUNCT_ADD);
      KindSub: word_o = enc_r(rs_i, rt_i, rd_i, FUNCT_SUB);
      KindAnd: word_o = enc_r(rs_i, rt_i, rd_i, FUNCT_AND);
      KindOr:  word_o = enc_r(rs_i, rt_i, rd_i, FUNCT_OR);
      KindSlt: word_o = enc_r(rs_i, rt_i, rd_i, FUNCT_SLT);
      KindLw:  word_o = enc_i(OP_LW, rs_i, rt_i, imm_i);
      KindSw:  word_o = enc_i(OP_SW, rs_i, rt_i, imm_i);
      KindBeq: word_o = enc_i(OP_BEQ, rs_i, rt_i, imm_i);
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Program loader: accepts instruction tokens over valid/ready, encodes them and writes
// them sequentially into instruction memory, holding the CPU off until the load is done.
module instr_encoder_loader
  import instr_encoder_loader_pkg::*;
#(
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned ADDR_W = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               in_kind,
  input  logic [4:0]               in_rs,
  input  logic [4:0]               in_rt,
  input  logic [4:0]               in_rd,
  input  logic [15:0]              in_imm,
  input  logic                     in_last,
  output logic                     imem_we,
  output logic [ADDR_W-1:0]        imem_addr,
  output logic [31:0]              imem_wdata,
  output logic                     cpu_hold,
  output logic                     done,
  output logic                     error,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  state_e              state_q, state_d;
  logic [CntW-1:0]     count_q, count_d;
  logic                we_q, we_d;
  logic                last_q, last_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [CntW:0]       fill;
  logic                accept;
  logic [31:0]         enc_word;
  logic                enc_illegal;

  instr_word_encoder u_encoder (
    .kind_i    (in_kind),
    .rs_i      (in_rs),
    .rt_i      (in_rt),
    .rd_i      (in_rd),
    .imm_i     (in_imm),
    .word_o    (enc_word),
    .illegal_o (enc_illegal)
  );

  // Words committed plus the one in the write stage; also the index of the next write.
  assign fill     = {1'b0, count_q} + (CntW+1)'(we_q);
  assign in_ready = (state_q == StLoad) && !last_q && (fill < (CntW+1)'(DEPTH));
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    count_d = count_q + CntW'(we_q);
    we_d    = 1'b0;
    last_d  = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StLoad;
          count_d = '0;
        end
      end
      StLoad: begin
        if (accept && enc_illegal) begin
          state_d = StError;
        end else if (accept) begin
          we_d    = 1'b1;
          last_d  = in_last;
          addr_d  = ADDR_W'({fill[CntW-1:0], 2'b00});
          wdata_d = enc_word;
        end
        // The write in flight decides completion or overflow once it lands.
        if (we_q) begin
          if (last_q) begin
            state_d = StDone;
          end else if (count_q == CntW'(DEPTH - 1)) begin
            state_d = StError;
          end
        end
      end
      StError: begin
        state_d = StError;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      count_q <= '0;
      we_q    <= 1'b0;
      last_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      we_q    <= we_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign cpu_hold   = (state_q != StDone);
  assign done       = (state_q == StDone);
  assign error      = (state_q == StError);
  assign count      = count_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for the program loader: a DEPTH=64 instance for the main flows and a
// DEPTH=4 instance for the overflow boundary.
module tb_instr_encoder_loader;

  logic        clk = 1'b0;
  logic        reset;
  always #5 clk = ~clk;

  logic        start, in_valid, in_last, in_ready;
  logic [3:0]  in_kind;
  logic [4:0]  in_rs, in_rt, in_rd;
  logic [15:0] in_imm;
  logic        imem_we, cpu_hold, done, error;
  logic [31:0] imem_addr, imem_wdata;
  logic [6:0]  count;

  logic        s_start, s_valid, s_last, s_ready;
  logic [3:0]  s_kind;
  logic [4:0]  s_rs, s_rt, s_rd;
  logic [15:0] s_imm;
  logic        s_we, s_hold, s_done, s_error;
  logic [31:0] s_addr, s_wdata;
  logic [2:0]  s_count;

  int n_vec = 0;
  int n_err = 0;

  instr_encoder_loader #(.DEPTH(64), .ADDR_W(32)) u_dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
    .in_last(in_last), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_hold(cpu_hold), .done(done), .error(error), .count(count)
  );

  instr_encoder_loader #(.DEPTH(4), .ADDR_W(32)) u_small (
    .clk(clk), .reset(reset), .start(s_start), .in_valid(s_valid), .in_ready(s_ready),
    .in_kind(s_kind), .in_rs(s_rs), .in_rt(s_rt), .in_rd(s_rd), .in_imm(s_imm),
    .in_last(s_last), .imem_we(s_we), .imem_addr(s_addr), .imem_wdata(s_wdata),
    .cpu_hold(s_hold), .done(s_done), .error(s_error), .count(s_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; s_start = 1'b0; s_valid = 1'b0;
    step();
    reset = 1'b0;
  endtask

  task automatic drive(input logic [3:0] k, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [15:0] imm, input logic last);
    in_kind = k; in_rs = rs; in_rt = rt; in_rd = rd; in_imm = imm; in_last = last;
  endtask

  task automatic test_reset();
    in_kind = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_imm = '0; in_last = 1'b0;
    s_kind = '0; s_rs = '0; s_rt = '0; s_rd = '0; s_imm = '0; s_last = 1'b0;
    do_reset();
    step();
    n_vec++;
    if ({in_ready, imem_we, cpu_hold, done, error} !== 5'b00100) begin
      n_err++;
      $display("FAIL reset_flags: got %b want 00100", {in_ready, imem_we, cpu_hold, done, error});
    end
    n_vec++;
    if (imem_addr !== 32'h0 || imem_wdata !== 32'h0 || count !== 7'd0) begin
      n_err++;
      $display("FAIL reset_data: got addr %h wdata %h count %0d want 0 0 0",
               imem_addr, imem_wdata, count);
    end
    n_vec++;
    if ({s_ready, s_we, s_hold, s_done, s_error, s_count} !== 8'b00100_000) begin
      n_err++;
      $display("FAIL reset_small: got %b want 00100000",
               {s_ready, s_we, s_hold, s_done, s_error, s_count});
    end
  endtask

  task automatic test_single_add();
    do_reset();
    start = 1'b1; step(); start = 1'b0;
    n_vec++;
    if (in_ready !== 1'b1 || cpu_hold !== 1'b1) begin
      n_err++;
      $display("FAIL add_ready: got ready %b hold %b want 1 1", in_ready, cpu_hold);
    end
    drive(4'd0, 5'd1, 5'd2, 5'd3, 16'hBEEF, 1'b0);
    in_valid = 1'b1; step(); in_valid = 1'b0;
    n_vec++;
    if (imem_we !== 1'b1 || imem_addr !== 32'h0 || imem_wdata !== 32'h00221820 || count !== 7'd0)
    begin
      n_err++;
      $display("FAIL add_write: got we %b addr %h wdata %h count %0d want 1 0 00221820 0",
               imem_we, imem_addr, imem_wdata, count);
    end
    step();
    n_vec++;
    if (imem_we !== 1'b0 || count !== 7'd1 || imem_wdata !== 32'h00221820) begin
      n_err++;
      $display("FAIL add_after: got we %b count %0d wdata %h want 0 1 00221820",
               imem_we, count, imem_wdata);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    start = 1'b1; step(); start = 1'b0;
    drive(4'd5, 5'd29, 5'd8, 5'd17, 16'h0004, 1'b0);
    in_valid = 1'b1; step();
    n_vec++;
    if (imem_we !== 1'b1 || imem_addr !== 32'h0 || imem_wdata !== 32'h8FA80004 || in_ready !== 1'b1)
    begin
      n_err++;
      $display("FAIL b2b_lw: got we %b addr %h wdata %h ready %b want 1 0 8fa80004 1",
               imem_we, imem_addr, imem_wdata, in_ready);
    end
    drive(4'd7, 5'd1, 5'd2, 5'd0, 16'hFFFF, 1'b1);
    step();
    n_vec++;
    if (imem_we !== 1'b1 || imem_addr !== 32'h4 || imem_wdata !== 32'h1022FFFF || in_ready !== 1'b0)
    begin
      n_err++;
      $display("FAIL b2b_beq: got we %b addr %h wdata %h ready %b want 1 4 1022ffff 0",
               imem_we, imem_addr, imem_wdata, in_ready);
    end
    drive(4'd0, 5'd4, 5'd4, 5'd4, 16'h0, 1'b0);
    step();
    n_vec++;
    if ({done, cpu_hold, imem_we, in_ready} !== 4'b1000 || count !== 7'd2) begin
      n_err++;
      $display("FAIL b2b_done: got done/hold/we/ready %b count %0d want 1000 2",
               {done, cpu_hold, imem_we, in_ready}, count);
    end
    step();
    n_vec++;
    if (imem_we !== 1'b0 || count !== 7'd2 || imem_addr !== 32'h4) begin
      n_err++;
      $display("FAIL after_last: got we %b count %0d addr %h want 0 2 4", imem_we, count, imem_addr);
    end
    in_valid = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    n_vec++;
    if ({done, cpu_hold, in_ready} !== 3'b011 || count !== 7'd0) begin
      n_err++;
      $display("FAIL restart: got done/hold/ready %b count %0d want 011 0",
               {done, cpu_hold, in_ready}, count);
    end
  endtask

  task automatic test_illegal();
    do_reset();
    start = 1'b1; step(); start = 1'b0;
    drive(4'd1, 5'd3, 5'd4, 5'd5, 16'h0, 1'b0);
    in_valid = 1'b1; step();
    drive(4'd9, 5'd3, 5'd4, 5'd5, 16'h0, 1'b0);
    step();
    n_vec++;
    if ({imem_we, error, in_ready, cpu_hold, done} !== 5'b01010 || count !== 7'd1) begin
      n_err++;
      $display("FAIL illegal: got we/err/ready/hold/done %b count %0d want 01010 1",
               {imem_we, error, in_ready, cpu_hold, done}, count);
    end
    drive(4'd0, 5'd1, 5'd1, 5'd1, 16'h0, 1'b0);
    start = 1'b1; step(); step(); start = 1'b0; in_valid = 1'b0;
    n_vec++;
    if ({imem_we, error, in_ready, cpu_hold} !== 4'b0101) begin
      n_err++;
      $display("FAIL error_sticky: got we/err/ready/hold %b want 0101",
               {imem_we, error, in_ready, cpu_hold});
    end
    do_reset();
    step();
    n_vec++;
    if (error !== 1'b0 || cpu_hold !== 1'b1) begin
      n_err++;
      $display("FAIL error_clear: got err %b hold %b want 0 1", error, cpu_hold);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    s_start = 1'b1; step(); s_start = 1'b0;
    s_valid = 1'b1; s_kind = 4'd0; s_rs = 5'd1; s_rt = 5'd2; s_last = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s_rd = 5'(i + 3);
      step();
      n_vec++;
      if (s_we !== 1'b1 || s_addr !== 32'(i * 4) || s_wdata !== 32'h00221820 + (32'(i) << 11))
      begin
        n_err++;
        $display("FAIL ovf_write%0d: got we %b addr %h wdata %h want 1 %h %h", i, s_we, s_addr,
                 s_wdata, 32'(i * 4), 32'h00221820 + (32'(i) << 11));
      end
    end
    n_vec++;
    if (s_ready !== 1'b0) begin
      n_err++;
      $display("FAIL ovf_full: got ready %b want 0", s_ready);
    end
    s_rd = 5'd20;
    step();
    n_vec++;
    if ({s_we, s_error, s_ready, s_done} !== 4'b0100 || s_count !== 3'd4) begin
      n_err++;
      $display("FAIL ovf_error: got we/err/ready/done %b count %0d want 0100 4",
               {s_we, s_error, s_ready, s_done}, s_count);
    end
    step();
    s_valid = 1'b0;
    n_vec++;
    if (s_we !== 1'b0 || s_count !== 3'd4) begin
      n_err++;
      $display("FAIL ovf_fifth: got we %b count %0d want 0 4", s_we, s_count);
    end
  endtask

  task automatic test_random_stall();
    logic [3:0]  rk  [6] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd6, 4'd5};
    logic [4:0]  rrs [6] = '{5'd3, 5'd6, 5'd9, 5'd12, 5'd0, 5'd2};
    logic [4:0]  rrt [6] = '{5'd4, 5'd7, 5'd10, 5'd13, 5'd9, 5'd3};
    logic [4:0]  rrd [6] = '{5'd5, 5'd8, 5'd11, 5'd14, 5'd31, 5'd31};
    logic [15:0] rim [6] = '{16'hBEEF, 16'hBEEF, 16'hBEEF, 16'hBEEF, 16'h0008, 16'h1234};
    logic [31:0] rex [6] = '{32'h00642822, 32'h00C74024, 32'h012A5825, 32'h018D702A,
                             32'hAC090008, 32'h8C431234};
    int k = 0;
    int cyc = 0;
    logic acc;
    do_reset();
    start = 1'b1; step(); start = 1'b0;
    while (k < 6 && cyc < 200) begin
      in_valid = 1'($urandom_range(0, 1));
      drive(rk[k], rrs[k], rrt[k], rrd[k], rim[k], k == 5);
      acc = in_valid && in_ready;
      step();
      cyc++;
      n_vec++;
      if (acc) begin
        if (imem_we !== 1'b1 || imem_addr !== 32'(k * 4) || imem_wdata !== rex[k]) begin
          n_err++;
          $display("FAIL rand_word%0d: got we %b addr %h wdata %h want 1 %h %h", k, imem_we,
                   imem_addr, imem_wdata, 32'(k * 4), rex[k]);
        end
        k++;
      end else if (imem_we !== 1'b0) begin
        n_err++;
        $display("FAIL rand_spurious: got we %b want 0 at token %0d", imem_we, k);
      end
    end
    in_valid = 1'b0;
    n_vec++;
    if (k != 6) begin
      n_err++;
      $display("FAIL rand_timeout: got %0d tokens want 6", k);
    end
    step();
    n_vec++;
    if ({done, cpu_hold, imem_we} !== 3'b100 || count !== 7'd6) begin
      n_err++;
      $display("FAIL rand_done: got done/hold/we %b count %0d want 100 6",
               {done, cpu_hold, imem_we}, count);
    end
  endtask

  task automatic test_reset_midload();
    do_reset();
    start = 1'b1; step(); start = 1'b0;
    drive(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 1'b0);
    in_valid = 1'b1; step(); step();
    in_valid = 1'b0; step();
    n_vec++;
    if (count !== 7'd2) begin
      n_err++;
      $display("FAIL mid_count: got %0d want 2", count);
    end
    reset = 1'b1; step(); reset = 1'b0;
    n_vec++;
    if ({in_ready, imem_we, cpu_hold, done, error} !== 5'b00100 || imem_addr !== 32'h0 ||
        imem_wdata !== 32'h0 || count !== 7'd0) begin
      n_err++;
      $display("FAIL mid_reset: got flags %b addr %h wdata %h count %0d want 00100 0 0 0",
               {in_ready, imem_we, cpu_hold, done, error}, imem_addr, imem_wdata, count);
    end
    start = 1'b1; step(); start = 1'b0;
    drive(4'd6, 5'd0, 5'd9, 5'd7, 16'h0008, 1'b0);
    in_valid = 1'b1; step(); in_valid = 1'b0;
    n_vec++;
    if (imem_we !== 1'b1 || imem_addr !== 32'h0 || imem_wdata !== 32'hAC090008) begin
      n_err++;
      $display("FAIL reload_sw: got we %b addr %h wdata %h want 1 0 ac090008",
               imem_we, imem_addr, imem_wdata);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; s_start = 1'b0; s_valid = 1'b0;
    test_reset();
    test_single_add();
    test_back_to_back();
    test_illegal();
    test_overflow();
    test_random_stall();
    test_reset_midload();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
